// File: rtl/wb_trace_display_if.sv
// wb_trace_display_if: write-back capture bus plus OLED character write port.
// master drives the write-back side, slave is the trace display.
interface wb_trace_display_if;
  logic [5:0]  op_w;
  logic [4:0]  wreg_w;
  logic [31:0] result_w;
  logic        disp_we;
  logic [5:0]  disp_addr;
  logic [7:0]  disp_data;

  modport master (
    output op_w,
    output wreg_w,
    output result_w,
    input  disp_we,
    input  disp_addr,
    input  disp_data
  );

  modport slave (
    input  op_w,
    input  wreg_w,
    input  result_w,
    output disp_we,
    output disp_addr,
    output disp_data
  );
endinterface

// File: rtl/wb_trace_display.sv
// wb_trace_display: FIFO of retired writes rendered as 16-char OLED lines.
// Optional macro WB_TRACE_OVF_MARK_EN: flag the line preceding a drop with '!'.
module wb_trace_display #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHAR_GAP = 0
) (
  input  logic              sysclk,
  input  logic              cpu_resetn,
  wb_trace_display_if.slave bus,
  output logic              fifo_full,
  output logic              overflow,
  output logic              busy,
  output logic              halted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  GAP_LAST = 8'(CHAR_GAP);
  localparam logic [5:0]  OP_HALT  = 6'h3F;

  typedef struct packed {
`ifdef WB_TRACE_OVF_MARK_EN
    logic        mark;
`endif
    logic        halt;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    EMIT,
    GAP
  } state_e;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          halted_q;

  state_e        state_q;
  entry_t        cur_q;
  logic [3:0]    col_q;
  logic [1:0]    line_q;
  logic [7:0]    gap_q;
  logic          we_q;
  logic [5:0]    addr_q;
  logic [7:0]    data_q;

  logic   cap_halt;
  logic   push_req;
  logic   pop;
  logic   full;
  logic   push_ok;
  logic   drop;
  logic [3:0] col_nx;
  entry_t new_e;

  function automatic logic [7:0] hex_c(
    input logic [3:0] d
  );
    if (d < 4'd10) return 8'h30 + {4'h0, d};
    return 8'h37 + {4'h0, d};
  endfunction

  function automatic logic [7:0] char_at(
    input entry_t     e,
    input logic [3:0] col
  );
    logic [7:0] c;
    logic [1:0] tens;
    logic [4:0] units;
    logic [3:0] nib;
    c    = 8'h20;
    tens = 2'd0;
    if (e.rd >= 5'd30)      tens = 2'd3;
    else if (e.rd >= 5'd20) tens = 2'd2;
    else if (e.rd >= 5'd10) tens = 2'd1;
    units = e.rd - (5'(tens) * 5'd10);
    unique case (col)
      4'd4:    nib = e.data[31:28];
      4'd5:    nib = e.data[27:24];
      4'd6:    nib = e.data[23:20];
      4'd7:    nib = e.data[19:16];
      4'd8:    nib = e.data[15:12];
      4'd9:    nib = e.data[11:8];
      4'd10:   nib = e.data[7:4];
      4'd11:   nib = e.data[3:0];
      default: nib = 4'h0;
    endcase
    if (e.halt) begin
      unique case (col)
        4'd0:    c = 8'h48;
        4'd1:    c = 8'h41;
        4'd2:    c = 8'h4C;
        4'd3:    c = 8'h54;
        default: c = 8'h20;
      endcase
    end else begin
      if (col == 4'd0)       c = 8'h52;
      else if (col == 4'd1)  c = 8'h30 + {6'd0, tens};
      else if (col == 4'd2)  c = 8'h30 + {3'd0, units};
      else if (col == 4'd3)  c = 8'h3D;
      else if (col <= 4'd11) c = hex_c(nib);
    end
`ifdef WB_TRACE_OVF_MARK_EN
    if (e.mark && col == 4'd15) c = 8'h21;
`endif
    return c;
  endfunction

  assign cap_halt = !halted_q && (bus.op_w == OP_HALT);
  assign push_req = cap_halt ||
                    (!halted_q && bus.wreg_w != 5'd0);
  assign pop      = (state_q == POP);
  assign full     = (cnt_q == FULL_CNT);
  // A pop on the same edge frees the slot being pushed.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign col_nx   = col_q + 4'd1;

  always_comb begin
    new_e      = '0;
    new_e.halt = cap_halt;
    if (!cap_halt) begin
      new_e.rd   = bus.wreg_w;
      new_e.data = bus.result_w;
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= new_e;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop)
        cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push_ok)
        cnt_q <= cnt_q - (AW+1)'(1);
      if (drop)
        ovf_q <= 1'b1;
      if (cap_halt)
        halted_q <= 1'b1;
`ifdef WB_TRACE_OVF_MARK_EN
      // Flag the newest queued line: the gap follows it.
      if (drop)
        mem_q[wptr_q - AW'(1)].mark <= 1'b1;
`endif
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= IDLE;
      cur_q   <= '0;
      col_q   <= 4'd0;
      line_q  <= 2'd0;
      gap_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 6'd0;
      data_q  <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_q != '0)
            state_q <= POP;
        end
        POP: begin
          cur_q   <= mem_q[rptr_q];
          col_q   <= 4'd0;
          state_q <= EMIT;
          we_q    <= 1'b1;
          addr_q  <= {line_q, 4'd0};
          data_q  <= char_at(mem_q[rptr_q], 4'd0);
        end
        EMIT: begin
          if (col_q == 4'd15) begin
            line_q  <= line_q + 2'd1;
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 6'd0;
            data_q  <= 8'd0;
          end else if (CHAR_GAP != 0) begin
            state_q <= GAP;
            gap_q   <= 8'd1;
            we_q    <= 1'b0;
            addr_q  <= 6'd0;
            data_q  <= 8'd0;
          end else begin
            col_q  <= col_nx;
            we_q   <= 1'b1;
            addr_q <= {line_q, col_nx};
            data_q <= char_at(cur_q, col_nx);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            col_q   <= col_nx;
            state_q <= EMIT;
            we_q    <= 1'b1;
            addr_q  <= {line_q, col_nx};
            data_q  <= char_at(cur_q, col_nx);
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.disp_we   = we_q;
  assign bus.disp_addr = addr_q;
  assign bus.disp_data = data_q;
  assign fifo_full     = full;
  assign overflow      = ovf_q;
  assign busy          = (state_q != IDLE) || (cnt_q != '0);
  assign halted        = halted_q;

endmodule

// File: tb/tb_wb_trace_display.sv
// tb_wb_trace_display: table vectors, directed corner sequences and a
// random run against a timing-level queue model, for CHAR_GAP 0 and 2.
module tb_wb_trace_display;

  localparam int DEPTH = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_trace_display_if b0 ();
  wb_trace_display_if b1 ();

  logic full0, ovf0, busy0, halt0;
  logic full1, ovf1, busy1, halt1;

  wb_trace_display #(.DEPTH(DEPTH), .CHAR_GAP(0)) dut0 (
    .sysclk    (clk),
    .cpu_resetn(rstn),
    .bus       (b0),
    .fifo_full (full0),
    .overflow  (ovf0),
    .busy      (busy0),
    .halted    (halt0)
  );

  wb_trace_display #(.DEPTH(DEPTH), .CHAR_GAP(2)) dut1 (
    .sysclk    (clk),
    .cpu_resetn(rstn),
    .bus       (b1),
    .fifo_full (full1),
    .overflow  (ovf1),
    .busy      (busy1),
    .halted    (halt1)
  );

  typedef struct {
    int         e;
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int          m;
    int          pop;
    bit          halt;
    logic [4:0]  rd;
    logic [31:0] d;
    bit          mark;
    int          line;
  } ent_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    string       txt;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_k;
  wr_t  got0[$];
  wr_t  got1[$];
  wr_t  expq[$];
  ent_t acc[$];
  int   last_pop[2];
  int   nacc[2];
  bit   mhalt[2];
  bit   movf[2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b0.disp_we === 1'b1) got0.push_back('{cyc, b0.disp_addr, b0.disp_data});
    if (b1.disp_we === 1'b1) got1.push_back('{cyc, b1.disp_addr, b1.disp_data});
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int gap_of(input int m);
    return (m == 0) ? 0 : 2;
  endfunction

  task automatic model_reset();
    acc.delete();
    for (int m = 0; m < 2; m++) begin
      last_pop[m] = -1000;
      nacc[m]     = 0;
      mhalt[m]    = 1'b0;
      movf[m]     = 1'b0;
    end
  endtask

  // Pop edge of each line: two edges after its push, or one line time
  // (16 + 15*gap) plus two idle/pop edges after the previous pop.
  task automatic model_step(input int k, input logic [5:0] op,
                            input logic [4:0] wr, input logic [31:0] d);
    for (int m = 0; m < 2; m++) begin
      int occ;
      int pop;
      int last;
      if (mhalt[m] || !(op == 6'h3F || wr != 5'd0)) continue;
      if (op == 6'h3F) mhalt[m] = 1'b1;
      occ  = 0;
      last = -1;
      foreach (acc[i]) begin
        if (acc[i].m == m) begin
          last = i;
          if (acc[i].pop > k) occ++;
        end
      end
      if (occ >= DEPTH) begin
        movf[m] = 1'b1;
`ifdef WB_TRACE_OVF_MARK_EN
        if (last >= 0) acc[last].mark = 1'b1;
`endif
      end else begin
        pop = last_pop[m] + 18 + 15 * gap_of(m);
        if (k + 2 > pop) pop = k + 2;
        acc.push_back('{m, pop, op == 6'h3F, wr, d, 1'b0, nacc[m] % 4});
        nacc[m]++;
        last_pop[m] = pop;
      end
    end
  endtask

  function automatic string line_text(input ent_t e);
    string s;
    if (e.halt) s = "HALT            ";
    else begin
      s = $sformatf("R%0d%0d=%h    ", e.rd / 10, e.rd % 10, e.d);
      s = s.toupper();
    end
    if (e.mark) s.putc(15, "!");
    return s;
  endfunction

  task automatic build_exp(input int m);
    expq.delete();
    foreach (acc[i]) begin
      if (acc[i].m == m) begin
        string s;
        s = line_text(acc[i]);
        for (int c = 0; c < 16; c++)
          expq.push_back('{acc[i].pop + c * (gap_of(m) + 1),
                           {2'(acc[i].line), 4'(c)}, s.getc(c)});
      end
    end
  endtask

  task automatic compare_model(input string tag, input int m);
    wr_t g[$];
    int  n;
    build_exp(m);
    if (m == 0) g = got0;
    else g = got1;
    chk($sformatf("%s_m%0d_nwr", tag, m), g.size(), expq.size());
    n = (g.size() < expq.size()) ? g.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_m%0d_wr%0d{edge,addr,data}", tag, m, i),
          {32'(g[i].e), g[i].a, g[i].d},
          {32'(expq[i].e), expq[i].a, expq[i].d});
    chk($sformatf("%s_m%0d_ovf", tag, m), (m == 0) ? ovf0 : ovf1, movf[m]);
    chk($sformatf("%s_m%0d_halt", tag, m), (m == 0) ? halt0 : halt1, mhalt[m]);
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] wr, input logic [31:0] d);
    b0.op_w = op; b0.wreg_w = wr; b0.result_w = d;
    b1.op_w = op; b1.wreg_w = wr; b1.result_w = d;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] wr, input logic [31:0] d);
    @(negedge clk); #1;
    set_in(op, wr, d);
    last_k = cyc + 1;
    model_step(last_k, op, wr, d);
  endtask

  task automatic drain();
    int n;
    drive(6'd0, 5'd0, 32'd0);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy0 || busy1) && n < 4000);
    chk("drain_in_time", n < 4000, 1'b1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rstn = 1'b0;
    set_in(6'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out0", {b0.disp_we, b0.disp_addr, b0.disp_data, full0, ovf0, busy0, halt0}, 0);
    chk("rst_out1", {b1.disp_we, b1.disp_addr, b1.disp_data, full1, ovf1, busy1, halt1}, 0);
    got0.delete();
    got1.delete();
    model_reset();
    rstn = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vt[6];
    string s;
    int    k;
    int    n;

    vt[0] = '{5'd9,  32'h00000037, "R09=00000037    "};
    vt[1] = '{5'd31, 32'hDEADBEEF, "R31=DEADBEEF    "};
    vt[2] = '{5'd10, 32'h0123ABCD, "R10=0123ABCD    "};
    vt[3] = '{5'd1,  32'hFFFFFFFF, "R01=FFFFFFFF    "};
    vt[4] = '{5'd20, 32'h9A000000, "R20=9A000000    "};
    vt[5] = '{5'd19, 32'h00000000, "R19=00000000    "};

    set_in(6'd0, 5'd0, 32'd0);
    model_reset();

    foreach (vt[i]) begin
      do_reset();
      drive(6'd0, vt[i].rd, vt[i].d);
      k = last_k;
      drain();
      chk($sformatf("tbl%0d_nwr", i), got0.size(), 16);
      chk($sformatf("tbl%0d_busy", i), busy0, 1'b0);
      if (got0.size() == 16) begin
        chk($sformatf("tbl%0d_first_edge", i), got0[0].e, k + 2);
        for (int c = 0; c < 16; c++) begin
          chk($sformatf("tbl%0d_addr%0d", i, c), got0[c].a, c);
          chk($sformatf("tbl%0d_char%0d", i, c), got0[c].d, vt[i].txt.getc(c));
        end
      end
    end

    do_reset();
    for (int i = 1; i <= 7; i++) drive(6'd0, 5'(i), 32'(i));
    drive(6'd0, 5'd0, 32'd0);
    chk("ovf_full", full0, 1'b1);
    drain();
    chk("ovf_nwr", got0.size(), 80);
    chk("ovf_flag", ovf0, 1'b1);
    if (got0.size() == 80) begin
      for (int l = 0; l < 5; l++) begin
        logic [7:0] e15;
        e15 = 8'h20;
`ifdef WB_TRACE_OVF_MARK_EN
        if (l == 4) e15 = 8'h21;
`endif
        chk($sformatf("ovf_l%0d_reg", l), got0[16*l+2].d, 8'h31 + 8'(l));
        chk($sformatf("ovf_l%0d_col15", l), got0[16*l+15].d, e15);
      end
      for (int c = 0; c < 16; c++)
        chk($sformatf("ovf_wrap_addr%0d", c), got0[64+c].a, c);
    end
    compare_model("ovf", 0);
    compare_model("ovf", 1);

    do_reset();
    drive(6'h3F, 5'd0, 32'd0);
    drive(6'd0, 5'd3, 32'h33);
    drain();
    chk("halt_flag", halt0, 1'b1);
    chk("halt_nwr", got0.size(), 16);
    s = "HALT            ";
    if (got0.size() == 16)
      for (int c = 0; c < 16; c++)
        chk($sformatf("halt_char%0d", c), got0[c].d, s.getc(c));
    compare_model("halt", 0);
    compare_model("halt", 1);

    do_reset();
    drive(6'd0, 5'd31, 32'hDEADBEEF);
    drain();
    s = "R31=DEADBEEF    ";
    chk("gap_nwr", got1.size(), 16);
    if (got1.size() == 16) begin
      for (int c = 0; c < 16; c++) begin
        chk($sformatf("gap_char%0d", c), got1[c].d, s.getc(c));
        if (c > 0) chk($sformatf("gap_space%0d", c), got1[c].e - got1[c-1].e, 3);
      end
      chk("gap_span", got1[15].e - got1[0].e + 1, 46);
    end
    compare_model("gap", 1);

    do_reset();
    drive(6'd0, 5'd1, 32'h11);
    drive(6'd0, 5'd2, 32'h22);
    drive(6'd0, 5'd3, 32'h33);
    n = 0;
    do begin
      drive(6'd0, 5'd0, 32'd0);
      n++;
    end while (got0.size() < 24 && n < 300);
    chk("rstmid_reached", got0.size(), 24);
    chk("rstmid_addr", b0.disp_addr, {2'd1, 4'd7});
    rstn = 1'b0;
    #1;
    chk("rstmid_async0", {b0.disp_we, b0.disp_addr, b0.disp_data, full0, ovf0, busy0, halt0}, 0);
    chk("rstmid_async1", {b1.disp_we, b1.disp_addr, b1.disp_data, full1, ovf1, busy1, halt1}, 0);
    @(negedge clk); #1;
    got0.delete();
    got1.delete();
    model_reset();
    rstn = 1'b1;
    repeat (5) drive(6'd0, 5'd0, 32'd0);
    chk("rstmid_empty", {busy0, busy1, got0.size() == 0}, 3'b001);
    drive(6'd0, 5'd5, 32'h55);
    drain();
    chk("rstmid_nwr", got0.size(), 16);
    if (got0.size() > 0) chk("rstmid_line0", got0[0].a, 6'd0);
    compare_model("rstmid", 0);
    compare_model("rstmid", 1);

    for (int r = 0; r < 4; r++) begin
      int rate;
      rate = 10 + 15 * r;
      do_reset();
      for (int i = 0; i < 80; i++) begin
        int x;
        x = $urandom_range(0, 99);
        if (x < 2)
          drive(6'h3F, 5'($urandom_range(0, 31)), $urandom);
        else if (x < rate + 2)
          drive(6'($urandom_range(0, 62)), 5'($urandom_range(1, 31)), $urandom);
        else
          drive(6'($urandom_range(0, 62)), 5'd0, $urandom);
      end
      drain();
      compare_model($sformatf("rnd%0d", r), 0);
      compare_model($sformatf("rnd%0d", r), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
